// File: rtl/conv_pkg.sv
// Shared types and constants for the 32-to-16 converter.
// Mode encodings, FSM states and saturation limits.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_SPLIT = 2'b00,
    MODE_TRUNC = 2'b01,
    MODE_SATS  = 2'b10,
    MODE_SATU  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BEAT0 = 2'b01,
    ST_BEAT1 = 2'b10
  } state_e;

  localparam logic [15:0] SAT16_MAX  = 16'h7FFF;
  localparam logic [15:0] SAT16_MIN  = 16'h8000;
  localparam logic [15:0] SAT16_UMAX = 16'hFFFF;

  typedef struct packed {
    logic [31:0] data;
    mode_e       mode;
  } hold_t;

endpackage

// File: rtl/conv32to16_narrow.sv
// Combinational narrowing of a 32-bit word to one halfword.
// SPLIT is passed through; the top selects halves itself.
module conv32to16_narrow
  import conv_pkg::*;
(
  input  logic [31:0] word_i,
  input  mode_e       mode_i,
  output logic [15:0] val_o,
  output logic        sat_o
);

  logic pos_ovf;
  logic neg_ovf;

  // Signed overflow: the top 17 bits are not a pure sign extension.
  assign pos_ovf = ~word_i[31] & (|word_i[30:15]);
  assign neg_ovf =  word_i[31] & ~(&word_i[30:15]);

  // Clamp or truncate according to the sampled mode.
  always_comb begin
    val_o = word_i[15:0];
    sat_o = 1'b0;
    unique case (mode_i)
      MODE_SATS: begin
        if (pos_ovf) begin
          val_o = SAT16_MAX;
          sat_o = 1'b1;
        end else if (neg_ovf) begin
          val_o = SAT16_MIN;
          sat_o = 1'b1;
        end
      end
      MODE_SATU: begin
        if (|word_i[31:16]) begin
          val_o = SAT16_UMAX;
          sat_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/conv32to16.sv
// 32-bit to 16-bit stream converter with valid/ready on both sides.
// Outputs decode only from the held word and FSM state.
module conv32to16
  import conv_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_Data,
  input  logic [1:0]  Mode,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [15:0] Out_Data,
  output logic        Out_Last,
  output logic        Out_Sat
);

  state_e      state_q, state_d;
  hold_t       hold_q, hold_d;
  logic        live_q;
  logic        split;
  logic        last;
  logic        in_fire;
  logic [15:0] nar_val;
  logic        nar_sat;

  conv32to16_narrow u_narrow (
    .word_i (hold_q.data),
    .mode_i (hold_q.mode),
    .val_o  (nar_val),
    .sat_o  (nar_sat)
  );

  assign split   = (hold_q.mode == MODE_SPLIT);
  assign last    = (state_q == ST_BEAT1) |
                   ((state_q == ST_BEAT0) & ~split);
  assign In_Ready = Reset_n & live_q &
                    ((state_q == ST_IDLE) | (last & Out_Ready));
  assign in_fire = In_Valid & In_Ready;

  // State, hold register and post-reset guard cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      live_q  <= 1'b1;
    end
  end

  // Next state: advance on sink ready, reload on acceptance.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_BEAT0: begin
        if (Out_Ready) state_d = split ? ST_BEAT1 : ST_IDLE;
      end
      ST_BEAT1: begin
        if (Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (in_fire) begin
      state_d     = ST_BEAT0;
      hold_d.data = In_Data;
      hold_d.mode = mode_e'(Mode);
    end
  end

  // Beat decode from registered state only.
  always_comb begin
    Out_Valid = (state_q != ST_IDLE);
    Out_Last  = last;
    Out_Data  = '0;
    Out_Sat   = 1'b0;
    unique case (state_q)
      ST_BEAT0: begin
        if (split) begin
          Out_Data = HIGH_FIRST ? hold_q.data[31:16]
                                : hold_q.data[15:0];
        end else begin
          Out_Data = nar_val;
          Out_Sat  = nar_sat;
        end
      end
      ST_BEAT1: begin
        Out_Data = HIGH_FIRST ? hold_q.data[15:0]
                              : hold_q.data[31:16];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv32to16.sv
// Directed plus random bench for conv32to16.
// Expected beats come from a queue-based reference model.
module tb_conv32to16;

  localparam bit HF = 1'b0;
  localparam logic [1:0] SPLIT = 2'd0;
  localparam logic [1:0] TRUNC = 2'd1;
  localparam logic [1:0] SATS  = 2'd2;
  localparam logic [1:0] SATU  = 2'd3;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Data;
  logic [1:0]  Mode;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Data;
  logic        Out_Last;
  logic        Out_Sat;

  always #5 Clk = ~Clk;

  conv32to16 #(.HIGH_FIRST(HF)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .Mode      (Mode),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Last  (Out_Last),
    .Out_Sat   (Out_Sat)
  );

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        sat;
  } beat_t;

  beat_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int dut_last_beats = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void add(int unsigned v, logic l, logic s);
    beat_t b;
    b.d = 16'(v);
    b.last = l;
    b.sat = s;
    q.push_back(b);
  endfunction

  function automatic void push_word(logic [31:0] d, logic [1:0] m);
    int unsigned lo = d % 32'd65536;
    int unsigned hi = d / 32'd65536;
    longint s = longint'($signed(d));
    case (m)
      SPLIT: begin
        add(HF ? hi : lo, 1'b0, 1'b0);
        add(HF ? lo : hi, 1'b1, 1'b0);
      end
      TRUNC: add(lo, 1'b1, 1'b0);
      SATS: begin
        if (s > 32767)       add(32767, 1'b1, 1'b1);
        else if (s < -32768) add(32768, 1'b1, 1'b1);
        else                 add(lo, 1'b1, 1'b0);
      end
      default: begin
        if (d > 32'd65535) add(65535, 1'b1, 1'b1);
        else               add(lo, 1'b1, 1'b0);
      end
    endcase
  endfunction

  task automatic step(logic iv, logic [31:0] d, logic [1:0] m,
                      logic ordy);
    logic ov_e, ir_e;
    In_Valid = iv;
    In_Data = d;
    Mode = m;
    Out_Ready = ordy;
    #1;
    ov_e = (q.size() != 0);
    ir_e = (q.size() == 0) || (q.size() == 1 && ordy);
    chk("out_valid", 32'(Out_Valid), 32'(ov_e));
    chk("in_ready", 32'(In_Ready), 32'(ir_e));
    if (ov_e) begin
      chk("out_data", 32'(Out_Data), 32'(q[0].d));
      chk("out_last", 32'(Out_Last), 32'(q[0].last));
      chk("out_sat", 32'(Out_Sat), 32'(q[0].sat));
    end
    if (Out_Valid && Out_Ready && Out_Last) dut_last_beats++;
    if (ov_e && ordy) void'(q.pop_front());
    if (iv && ir_e) push_word(d, m);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(int n, logic iv_rel);
    Reset_n = 1'b0;
    In_Valid = 1'b0;
    Out_Ready = 1'b0;
    #1;
    chk("rst_in_ready_now", 32'(In_Ready), 0);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
    chk("rst_out_valid", 32'(Out_Valid), 0);
    chk("rst_out_data", 32'(Out_Data), 0);
    chk("rst_out_last", 32'(Out_Last), 0);
    chk("rst_out_sat", 32'(Out_Sat), 0);
    chk("rst_in_ready", 32'(In_Ready), 0);
    q.delete();
    Reset_n = 1'b1;
    In_Valid = iv_rel;
    In_Data = 32'h1234_5678;
    Mode = TRUNC;
    Out_Ready = 1'b1;
    @(posedge Clk);
    #1;
    chk("rel_out_valid", 32'(Out_Valid), 0);
    In_Valid = 1'b0;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] tbl[8];
    int base;
    tbl = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_8000,
            32'hFFFF_7FFF, 32'h0001_0000, 32'h0000_FFFF,
            32'h8000_0000, 32'h7FFF_FFFF};
    Reset_n = 1'b0;
    In_Valid = 1'b0;
    In_Data = '0;
    Mode = SPLIT;
    Out_Ready = 1'b0;
    @(posedge Clk);
    #1;
    do_reset(2, 1'b1);

    step(1'b1, 32'hFFFF_FFFE, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);

    step(1'b1, 32'hFFFF_FFFE, SATS, 1'b1);
    step(1'b1, 32'h0001_2345, SATS, 1'b1);
    step(1'b1, 32'hFFFE_0000, SATS, 1'b1);
    step(1'b0, 32'h0, SATS, 1'b1);
    step(1'b0, 32'h0, SATS, 1'b1);

    step(1'b1, 32'h0000_ABCD, SATU, 1'b1);
    step(1'b1, 32'h0001_0000, SATU, 1'b1);
    step(1'b1, 32'h1234_5678, TRUNC, 1'b1);
    step(1'b0, 32'h0, TRUNC, 1'b1);
    step(1'b0, 32'h0, TRUNC, 1'b1);

    step(1'b1, 32'h1111_2222, SPLIT, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'hDEAD_0000 + i, TRUNC, 1'b0);
    step(1'b0, 32'h0, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);

    step(1'b1, 32'hAAAA_5555, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);
    do_reset(1, 1'b0);
    step(1'b0, 32'h0, SPLIT, 1'b1);
    step(1'b0, 32'h0, SPLIT, 1'b1);

    base = dut_last_beats;
    for (int i = 0; i < 8; i++)
      step(1'b1, $urandom, TRUNC, 1'b1);
    step(1'b0, 32'h0, TRUNC, 1'b1);
    chk("trunc_burst_beats", 32'(dut_last_beats - base), 8);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      int k;
      k = $urandom_range(0, 11);
      d = (k < 4) ? $urandom : tbl[k - 4];
      step($urandom_range(0, 3) != 0, d,
           2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, SPLIT, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
